// File: rtl/axil_crossbar_wr.sv
// AXI-Lite write-path crossbar: forwards AW/W from the granted master to one
// slave port and routes B back to that master. The grant is captured when a
// transaction starts and is held until the B handshake completes.
module axil_crossbar_wr #(
  parameter int NUMBER_MASTER  = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                           aclk,
  input  logic                                           aresetn,
  input  logic [NUMBER_MASTER-1:0]                       grant_wr,
  // master ports
  input  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                       m_axil_awvalid,
  output logic [NUMBER_MASTER-1:0]                       m_axil_awready,
  input  logic [NUMBER_MASTER-1:0][AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  input  logic [NUMBER_MASTER-1:0][AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic [NUMBER_MASTER-1:0]                       m_axil_wvalid,
  output logic [NUMBER_MASTER-1:0]                       m_axil_wready,
  output logic [NUMBER_MASTER-1:0][1:0]                  m_axil_bresp,
  output logic [NUMBER_MASTER-1:0]                       m_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]                       m_axil_bready,
  // slave port
  output logic [AXI_ADDR_WIDTH-1:0]                      s_axil_awaddr,
  output logic                                           s_axil_awvalid,
  input  logic                                           s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]                      s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                    s_axil_wstrb,
  output logic                                           s_axil_wvalid,
  input  logic                                           s_axil_wready,
  input  logic [1:0]                                     s_axil_bresp,
  input  logic                                           s_axil_bvalid,
  output logic                                           s_axil_bready,
  // arbiter status
  output logic                                           wr_busy,
  output logic                                           wr_done
);

  localparam int IW = $clog2(NUMBER_MASTER);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_sel;
  logic [IW-1:0]   w_sel_nxt;
  logic            r_aw_done;
  logic            w_aw_done_nxt;
  logic            r_w_done;
  logic            w_w_done_nxt;

  logic [IW-1:0]   w_grant_idx;
  logic            w_grant_found;
  logic            w_aw_hs;
  logic            w_w_hs;

  // Lowest set grant bit selects the master when the grant is not one-hot.
  always_comb begin
    w_grant_idx   = '0;
    w_grant_found = 1'b0;
    for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
      if (grant_wr[i] && !w_grant_found) begin
        w_grant_idx   = IW'(i);
        w_grant_found = 1'b1;
      end
    end
  end

  // State, selected master and per-channel completion flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Next-state logic and channel steering; everything defaults to zero so
  // unselected masters and idle cycles see quiet outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    m_axil_awready = '0;
    m_axil_wready  = '0;
    m_axil_bresp   = '0;
    m_axil_bvalid  = '0;
    s_axil_awaddr  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b0;
    wr_done        = 1'b0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_grant_found) begin
          w_sel_nxt     = w_grant_idx;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = ADDR_DATA;
        end
      end

      ADDR_DATA: begin
        s_axil_awaddr         = m_axil_awaddr[r_sel];
        s_axil_awvalid        = m_axil_awvalid[r_sel] & ~r_aw_done;
        m_axil_awready[r_sel] = s_axil_awready & ~r_aw_done;
        s_axil_wdata          = m_axil_wdata[r_sel];
        s_axil_wstrb          = m_axil_wstrb[r_sel];
        s_axil_wvalid         = m_axil_wvalid[r_sel] & ~r_w_done;
        m_axil_wready[r_sel]  = s_axil_wready & ~r_w_done;
        w_aw_hs               = s_axil_awvalid & s_axil_awready;
        w_w_hs                = s_axil_wvalid & s_axil_wready;
        if (w_aw_hs) w_aw_done_nxt = 1'b1;
        if (w_w_hs)  w_w_done_nxt  = 1'b1;
        // Either channel may finish first; move on once both have.
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_state_nxt = RESP;
        end
      end

      RESP: begin
        m_axil_bvalid[r_sel] = s_axil_bvalid;
        m_axil_bresp[r_sel]  = s_axil_bresp;
        s_axil_bready        = m_axil_bready[r_sel];
        if (s_axil_bvalid & m_axil_bready[r_sel]) begin
          wr_done     = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign wr_busy = (r_state != IDLE);

endmodule

// File: tb/tb_axil_crossbar_wr.sv
// Directed bench for axil_crossbar_wr with two masters.
module tb_axil_crossbar_wr;

  logic                 aclk;
  logic                 aresetn;
  logic [1:0]           grant_wr;
  logic [1:0][31:0]     m_axil_awaddr;
  logic [1:0]           m_axil_awvalid;
  logic [1:0]           m_axil_awready;
  logic [1:0][31:0]     m_axil_wdata;
  logic [1:0][3:0]      m_axil_wstrb;
  logic [1:0]           m_axil_wvalid;
  logic [1:0]           m_axil_wready;
  logic [1:0][1:0]      m_axil_bresp;
  logic [1:0]           m_axil_bvalid;
  logic [1:0]           m_axil_bready;
  logic [31:0]          s_axil_awaddr;
  logic                 s_axil_awvalid;
  logic                 s_axil_awready;
  logic [31:0]          s_axil_wdata;
  logic [3:0]           s_axil_wstrb;
  logic                 s_axil_wvalid;
  logic                 s_axil_wready;
  logic [1:0]           s_axil_bresp;
  logic                 s_axil_bvalid;
  logic                 s_axil_bready;
  logic                 wr_busy;
  logic                 wr_done;

  int n_checks = 0;
  int n_errors = 0;

  axil_crossbar_wr #(
    .NUMBER_MASTER (2),
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .grant_wr      (grant_wr),
    .m_axil_awaddr (m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata  (m_axil_wdata),
    .m_axil_wstrb  (m_axil_wstrb),
    .m_axil_wvalid (m_axil_wvalid),
    .m_axil_wready (m_axil_wready),
    .m_axil_bresp  (m_axil_bresp),
    .m_axil_bvalid (m_axil_bvalid),
    .m_axil_bready (m_axil_bready),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .wr_busy       (wr_busy),
    .wr_done       (wr_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Every DUT output concatenated; used where all must be zero.
  function automatic logic [63:0] all_outs();
    return {m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
            s_axil_awvalid, s_axil_wvalid, s_axil_bready, wr_busy, wr_done,
            (|s_axil_awaddr), (|s_axil_wdata), (|s_axil_wstrb)};
  endfunction

  initial begin
    // Reset asserted while masters drive everything
    aresetn        = 1'b0;
    grant_wr       = 2'b11;
    m_axil_awaddr  = {32'hAAAA_0004, 32'h5555_0008};
    m_axil_awvalid = 2'b11;
    m_axil_wdata   = {32'h1111_2222, 32'h3333_4444};
    m_axil_wstrb   = {4'hF, 4'hF};
    m_axil_wvalid  = 2'b11;
    m_axil_bready  = 2'b11;
    s_axil_awready = 1'b1;
    s_axil_wready  = 1'b1;
    s_axil_bresp   = 2'b11;
    s_axil_bvalid  = 1'b1;
    #2;
    check_val("rst_outputs", all_outs(), 64'h0);
    tick(); tick();
    check_val("rst_held", all_outs(), 64'h0);
    check_val("rst_busy", {63'h0, wr_busy}, 64'h0);
    check_val("rst_done", {63'h0, wr_done}, 64'h0);

    // Quiet inputs, release reset
    grant_wr = '0; m_axil_awvalid = '0; m_axil_wvalid = '0; m_axil_bready = '0;
    s_axil_awready = 1'b0; s_axil_wready = 1'b0; s_axil_bvalid = 1'b0; s_axil_bresp = 2'b00;
    aresetn = 1'b1;
    tick(); tick();
    check_val("idle_no_grant", {63'h0, wr_busy}, 64'h0);

    // Test A: master 1, AW and W in the same cycle
    grant_wr         = 2'b10;
    m_axil_awaddr[1] = 32'h0000_1000;
    m_axil_wdata[1]  = 32'hDEAD_BEEF;
    m_axil_wstrb[1]  = 4'hF;
    m_axil_awvalid   = 2'b10;
    m_axil_wvalid    = 2'b10;
    s_axil_awready   = 1'b1;
    s_axil_wready    = 1'b1;
    #1;
    check_val("A_latency_awvalid", {63'h0, s_axil_awvalid}, 64'h0);
    tick();
    grant_wr = 2'b00;
    #1;
    check_val("A_awvalid", {63'h0, s_axil_awvalid}, 64'h1);
    check_val("A_awaddr", {32'h0, s_axil_awaddr}, 64'h1000);
    check_val("A_wvalid", {63'h0, s_axil_wvalid}, 64'h1);
    check_val("A_wdata", {32'h0, s_axil_wdata}, 64'hDEAD_BEEF);
    check_val("A_wstrb", {60'h0, s_axil_wstrb}, 64'hF);
    check_val("A_awready", {62'h0, m_axil_awready}, 64'h2);
    check_val("A_wready", {62'h0, m_axil_wready}, 64'h2);
    check_val("A_busy", {63'h0, wr_busy}, 64'h1);
    tick();
    m_axil_awvalid = 2'b00; m_axil_wvalid = 2'b00;
    s_axil_bvalid = 1'b1; s_axil_bresp = 2'b00; m_axil_bready = 2'b10;
    #1;
    check_val("A_bvalid", {62'h0, m_axil_bvalid}, 64'h2);
    check_val("A_bresp", {60'h0, m_axil_bresp}, 64'h0);
    check_val("A_bready", {63'h0, s_axil_bready}, 64'h1);
    check_val("A_wr_done", {63'h0, wr_done}, 64'h1);
    check_val("A_no_aw_in_resp", {63'h0, s_axil_awvalid}, 64'h0);
    tick();
    s_axil_bvalid = 1'b0; m_axil_bready = 2'b00;
    #1;
    check_val("A_done_pulse_end", {63'h0, wr_done}, 64'h0);
    check_val("A_back_idle", all_outs(), 64'h0);

    // Test B: master 0, W handshake at n, AW handshake at n+3, grant moves to 1
    grant_wr         = 2'b01;
    m_axil_awaddr[0] = 32'h0000_2000;
    m_axil_wdata[0]  = 32'h0BAD_F00D;
    m_axil_wstrb[0]  = 4'h5;
    m_axil_awvalid   = 2'b01;
    m_axil_wvalid    = 2'b01;
    m_axil_bready    = 2'b01;
    s_axil_awready   = 1'b0;
    s_axil_wready    = 1'b1;
    tick();
    grant_wr       = 2'b10;
    m_axil_awvalid = 2'b11;
    m_axil_wvalid  = 2'b11;
    #1;
    check_val("B_n_wvalid", {63'h0, s_axil_wvalid}, 64'h1);
    check_val("B_n_wstrb", {60'h0, s_axil_wstrb}, 64'h5);
    check_val("B_n_wready", {62'h0, m_axil_wready}, 64'h1);
    check_val("B_n_awready", {62'h0, m_axil_awready}, 64'h0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      #1;
      check_val($sformatf("B_n%0d_wvalid_gated", c), {63'h0, s_axil_wvalid}, 64'h0);
      check_val($sformatf("B_n%0d_wready", c), {62'h0, m_axil_wready}, 64'h0);
      check_val($sformatf("B_n%0d_not_resp", c), {63'h0, s_axil_bready}, 64'h0);
      check_val($sformatf("B_n%0d_awaddr", c), {32'h0, s_axil_awaddr}, 64'h2000);
    end
    tick();
    s_axil_awready = 1'b1;
    #1;
    check_val("B_n3_awready_m0_only", {62'h0, m_axil_awready}, 64'h1);
    check_val("B_n3_not_resp", {63'h0, s_axil_bready}, 64'h0);
    tick();
    m_axil_awvalid = 2'b00; m_axil_wvalid = 2'b00; grant_wr = 2'b00;
    s_axil_bvalid = 1'b1; s_axil_bresp = 2'b01;
    #1;
    check_val("B_resp_bvalid_m0", {62'h0, m_axil_bvalid}, 64'h1);
    check_val("B_resp_bresp", {60'h0, m_axil_bresp}, 64'h1);
    check_val("B_resp_done", {63'h0, wr_done}, 64'h1);
    tick();
    s_axil_bvalid = 1'b0; m_axil_bready = 2'b00;
    #1;
    check_val("B_idle", {63'h0, wr_busy}, 64'h0);

    // Test C: B backpressure for 4 cycles
    grant_wr       = 2'b01;
    m_axil_awvalid = 2'b01;
    m_axil_wvalid  = 2'b01;
    s_axil_awready = 1'b1;
    s_axil_wready  = 1'b1;
    tick();
    grant_wr = 2'b00;
    tick();
    m_axil_awvalid = 2'b00; m_axil_wvalid = 2'b00;
    s_axil_bvalid = 1'b1; s_axil_bresp = 2'b10; m_axil_bready = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_val($sformatf("C_hold%0d_bvalid", c), {62'h0, m_axil_bvalid}, 64'h1);
      check_val($sformatf("C_hold%0d_bresp", c), {60'h0, m_axil_bresp}, 64'h2);
      check_val($sformatf("C_hold%0d_done", c), {63'h0, wr_done}, 64'h0);
      tick();
    end
    m_axil_bready = 2'b01;
    #1;
    check_val("C_release_done", {63'h0, wr_done}, 64'h1);
    tick();
    s_axil_bvalid = 1'b0; m_axil_bready = 2'b00;
    #1;
    check_val("C_idle", {63'h0, wr_busy}, 64'h0);

    // Test D: grant 2'b11 serves master 0, then reset pulse during RESP
    grant_wr         = 2'b11;
    m_axil_awaddr[0] = 32'h0000_2000;
    m_axil_awaddr[1] = 32'h0000_3000;
    m_axil_awvalid   = 2'b11;
    m_axil_wvalid    = 2'b11;
    s_axil_awready   = 1'b0;
    s_axil_wready    = 1'b0;
    tick();
    #1;
    check_val("D_lowest_awaddr", {32'h0, s_axil_awaddr}, 64'h2000);
    s_axil_awready = 1'b1; s_axil_wready = 1'b1;
    #1;
    check_val("D_awready_m0", {62'h0, m_axil_awready}, 64'h1);
    tick();
    s_axil_bvalid = 1'b1; s_axil_bresp = 2'b11; m_axil_bready = 2'b00;
    #1;
    check_val("D_resp_bvalid", {62'h0, m_axil_bvalid}, 64'h1);
    aresetn = 1'b0;
    #1;
    check_val("D_async_rst_outputs", all_outs(), 64'h0);
    #3;
    aresetn  = 1'b1;
    grant_wr = 2'b00;
    tick();
    #1;
    check_val("D_after_rst_idle", all_outs(), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
